dcache_miss_servicer: RTL

// Responder side of the dCache miss-repair handshake. Sits between the dCache controller and main memory.

---
 rtl/dcache_miss_servicer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/dcache_miss_servicer.sv
// dCache miss servicer: optional dirty-victim writeback, then a beat-wise line
// refill from memory, finished with a one-cycle repair_resolved pulse.
//
// Ports:
//   clk, rst (sync, active-high)
//   read_miss_repair, missed_addr, victim_dirty, victim_addr, victim_data  : miss request
//   repair_resolved, fill_addr, fill_data                                   : refill result
//   mem_req_valid/ready/write/addr, mem_wdata                               : beat request bus
//   mem_rdata_valid, mem_rdata                                              : in-order read returns
module dcache_miss_servicer #(
  parameter int ADDR_W      = 32,
  parameter int LINE_BITS   = 128,
  parameter int MEM_DATA_W  = 32,
  parameter int OFFSET_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_miss_repair,
  input  logic [ADDR_W-1:0]     missed_addr,
  input  logic                  victim_dirty,
  input  logic [ADDR_W-1:0]     victim_addr,
  input  logic [LINE_BITS-1:0]  victim_data,
  output logic                  repair_resolved,
  output logic [ADDR_W-1:0]     fill_addr,
  output logic [LINE_BITS-1:0]  fill_data,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_write,
  output logic [ADDR_W-1:0]     mem_req_addr,
  output logic [MEM_DATA_W-1:0] mem_wdata,
  input  logic                  mem_rdata_valid,
  input  logic [MEM_DATA_W-1:0] mem_rdata
);

  localparam int BEATS = LINE_BITS / MEM_DATA_W;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BSH   = $clog2(MEM_DATA_W / 8);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
  localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'((1 << OFFSET_BITS) - 1);

  typedef enum logic [2:0] {
    IDLE, WB, RD_REQ, RD_WAIT, DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      maddr_q, maddr_d;
  logic [ADDR_W-1:0]      vaddr_q, vaddr_d;
  logic [LINE_BITS-1:0]   vdata_q, vdata_d;
  logic [CW-1:0]          rcnt_q, rcnt_d;
  logic [CW-1:0]          ridx_q, ridx_d;
  logic                   rall_q, rall_d;
  logic [LINE_BITS-1:0]   fill_q, fill_d;
  logic [ADDR_W-1:0]      faddr_q, faddr_d;

  logic [ADDR_W-1:0] mbase, vbase, bofs;
  logic              xfer, ret;

  assign mbase = maddr_q & ~OFS_MASK;
  assign vbase = vaddr_q & ~OFS_MASK;
  assign bofs  = ADDR_W'(rcnt_q) << BSH;
  assign xfer  = mem_req_valid && mem_req_ready;

  always_comb begin
    state_d         = state_q;
    maddr_d         = maddr_q;
    vaddr_d         = vaddr_q;
    vdata_d         = vdata_q;
    rcnt_d          = rcnt_q;
    ridx_d          = ridx_q;
    rall_d          = rall_q;
    fill_d          = fill_q;
    faddr_d         = faddr_q;
    mem_req_valid   = 1'b0;
    mem_req_write   = 1'b0;
    mem_req_addr    = '0;
    mem_wdata       = '0;
    repair_resolved = 1'b0;

    // Returns are only meaningful while a refill is in flight.
    ret = mem_rdata_valid && (state_q == RD_REQ || state_q == RD_WAIT);
    if (ret) begin
      fill_d[int'(ridx_q)*MEM_DATA_W +: MEM_DATA_W] = mem_rdata;
      ridx_d = ridx_q + 1'b1;
      if (ridx_q == LAST) rall_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (read_miss_repair) begin
          maddr_d = missed_addr;
          vaddr_d = victim_addr;
          vdata_d = victim_data;
          rcnt_d  = '0;
          ridx_d  = '0;
          rall_d  = 1'b0;
          state_d = victim_dirty ? WB : RD_REQ;
        end
      end
      WB: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = vbase + bofs;
        mem_wdata     = vdata_q[int'(rcnt_q)*MEM_DATA_W +: MEM_DATA_W];
        if (xfer) begin
          rcnt_d = rcnt_q + 1'b1;
          if (rcnt_q == LAST) begin
            rcnt_d  = '0;
            state_d = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = mbase + bofs;
        if (xfer) begin
          rcnt_d = rcnt_q + 1'b1;
          if (rcnt_q == LAST) begin
            rcnt_d  = '0;
            state_d = rall_d ? DONE : RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (rall_d) state_d = DONE;
      end
      DONE: begin
        repair_resolved = 1'b1;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // fill_addr is updated as DONE is entered so it is valid with the pulse.
    if (state_d == DONE && state_q != DONE) faddr_d = mbase;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      maddr_q <= '0;
      vaddr_q <= '0;
      vdata_q <= '0;
      rcnt_q  <= '0;
      ridx_q  <= '0;
      rall_q  <= 1'b0;
      fill_q  <= '0;
      faddr_q <= '0;
    end else begin
      state_q <= state_d;
      maddr_q <= maddr_d;
      vaddr_q <= vaddr_d;
      vdata_q <= vdata_d;
      rcnt_q  <= rcnt_d;
      ridx_q  <= ridx_d;
      rall_q  <= rall_d;
      fill_q  <= fill_d;
      faddr_q <= faddr_d;
    end
  end

  assign fill_data = fill_q;
  assign fill_addr = faddr_q;

endmodule
